rv32i_alu_decode_stage: RTL
===========================

Name: rv32i_alu_decode_stage

Overview:
- Registered decode stage that turns RV32I ALU-class instructions (OP, OP-IMM, LUI, AUIPC) into the 5-bit ALUctr code, operand selects, register addresses and immediate consumed by the core's ALU.
- Sits between fetch and execute. Valid/ready handshake on both sides, one-entry output register, flush input, and two event counters.

Parameters:
- CNT_W, 32, width of instr_count.
- ILL_CNT_W, 16, width of illegal_count (saturating).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_inst  in  32  instruction word
- in_pc  in  32  instruction PC
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_alu_ctr  out  5  ALUctr code
- out_a_sel  out  2  00=rs1, 01=pc, 10=zero
- out_b_sel  out  1  0=rs2, 1=imm
- out_rs1, out_rs2, out_rd  out  5 each  register addresses
- out_rd_we  out  1  writeback enable
- out_imm  out  32  sign-extended immediate
- out_pc  out  32  PC of bundle
- out_illegal  out  1  unsupported encoding
- instr_count  out  CNT_W  bundles handed to execute
- illegal_count  out  ILL_CNT_W  illegal bundles handed to execute, saturating

Behaviour:
- Reset: every output register and both counters are 0. This includes out_valid, out_alu_ctr, out_imm and out_illegal.
- Handshake: in_ready = !out_valid || out_ready (combinational). An input transfer is in_valid && in_ready. An output transfer is out_valid && out_ready.
- Latency: 1 cycle. A bundle accepted at edge N is valid after edge N.
- Output register:
  - On input transfer (no flush), all out_* load the decoded bundle and out_valid becomes 1.
  - On output transfer without input transfer, out_valid becomes 0.
  - Otherwise the output holds stable, including while out_valid && !out_ready.
- flush has priority. out_valid becomes 0 next cycle and any same-cycle input is dropped. Counters are not incremented for the flushed bundle. A same-cycle output transfer still counts.
- Decode, OP (0110011), by funct7/funct3:
  - 0000000: 000 add 00000, 001 sll 00010, 010 slt 00011, 011 sltu 00100, 100 xor 00101, 101 srl 00110, 110 or 01000, 111 and 01001.
  - 0100000: 000 sub 00001, 101 sra 00111.
  - Operand selects: a_sel=00, b_sel=0.
- Decode, OP-IMM (0010011), by funct3:
  - 000 addi 01010, 010 slti 01011, 011 sltiu 01100, 100 xori 01101, 110 ori 01110, 111 andi 01111.
  - 001 slli 10001, requires inst[31:25]=0000000.
  - 101 srli 10010 if inst[31:25]=0000000; srai 10011 if inst[31:25]=0100000.
  - imm = sign-extended inst[31:20]. For shifts, imm[4:0] is shamt.
  - Operand selects: a_sel=00, b_sel=1.
- Decode, LUI (0110111): alu_ctr 00000, a_sel=10, b_sel=1, imm={inst[31:12],12'b0}.
- Decode, AUIPC (0010111): same as LUI except a_sel=01.
- Register addresses: rd=inst[11:7] and rs1=inst[19:15] always. rs2=inst[24:20] for OP, 0 otherwise.
- out_rd_we = legal && rd!=0.
- Illegal encoding (any other opcode or an invalid funct combination):
  - out_illegal=1, alu_ctr=00000, rd_we=0, imm=0, a_sel=00, b_sel=0.
  - out_pc and the register addresses are still captured.
- Counters, on each output transfer:
  - instr_count += 1, wrapping modulo 2^CNT_W.
  - illegal_count += 1 if out_illegal, holding at all-ones once reached.
- Reset mid-transfer: rst wins over everything. The bundle is lost and the counters clear.

Test Plan:
- Reset, then in_inst=0x003100B3 (add x1,x2,x3) with out_ready=1 -> next cycle out_valid=1, alu_ctr=00000, rs1=2, rs2=3, rd=1, rd_we=1, b_sel=0; instr_count=1 after the transfer.
- in_inst=0x4020D193 (srai x3,x1,2) -> alu_ctr=10011, imm=0x00000402 (imm[4:0]=2), b_sel=1. Follow with 0xFFF00093 (addi x1,x0,-1) -> alu_ctr=01010, imm=0xFFFFFFFF.
- in_inst=0x12345037 (lui x0) with pc=0x100 -> a_sel=10, imm=0x12345000, rd_we=0. Then 0x00001117 (auipc x2) -> a_sel=01, imm=0x00001000, out_pc echoed.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no count. Release -> one transfer per cycle, instr_count increases by exactly the number of transfers.
- Flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, counters unchanged. 0x0000006F (jal) -> out_illegal=1, rd_we=0, illegal_count=1.
- Force illegal_count to all-ones via 65536 illegal transfers -> it saturates at 0xFFFF. Assert rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rv32i_alu_decode_stage.sv
// rv32i_alu_decode_stage
// Registered decode stage for RV32I ALU-class instructions (OP, OP-IMM, LUI,
// AUIPC). Produces the ALUctr code, operand selects, register addresses and
// immediate for the execute stage. Valid/ready on both sides with a single
// output register, a flush input, and transfer/illegal event counters.

module rv32i_alu_decode_stage #(
  parameter int CNT_W     = 32,
  parameter int ILL_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [31:0]          in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_alu_ctr,
  output logic [1:0]           out_a_sel,
  output logic                 out_b_sel,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic                 out_rd_we,
  output logic [31:0]          out_imm,
  output logic [31:0]          out_pc,
  output logic                 out_illegal,
  output logic [CNT_W-1:0]     instr_count,
  output logic [ILL_CNT_W-1:0] illegal_count
);

  // Major opcodes handled by this stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALUctr codes
  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_SLL   = 5'b00010;
  localparam logic [4:0] ALU_SLT   = 5'b00011;
  localparam logic [4:0] ALU_SLTU  = 5'b00100;
  localparam logic [4:0] ALU_XOR   = 5'b00101;
  localparam logic [4:0] ALU_SRL   = 5'b00110;
  localparam logic [4:0] ALU_SRA   = 5'b00111;
  localparam logic [4:0] ALU_OR    = 5'b01000;
  localparam logic [4:0] ALU_AND   = 5'b01001;
  localparam logic [4:0] ALU_ADDI  = 5'b01010;
  localparam logic [4:0] ALU_SLTI  = 5'b01011;
  localparam logic [4:0] ALU_SLTIU = 5'b01100;
  localparam logic [4:0] ALU_XORI  = 5'b01101;
  localparam logic [4:0] ALU_ORI   = 5'b01110;
  localparam logic [4:0] ALU_ANDI  = 5'b01111;
  localparam logic [4:0] ALU_SLLI  = 5'b10001;
  localparam logic [4:0] ALU_SRLI  = 5'b10010;
  localparam logic [4:0] ALU_SRAI  = 5'b10011;

  // Operand A select encodings
  localparam logic [1:0] ASEL_RS1  = 2'b00;
  localparam logic [1:0] ASEL_PC   = 2'b01;
  localparam logic [1:0] ASEL_ZERO = 2'b10;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  // Output register state
  logic                 valid_reg;
  logic [4:0]           alu_ctr_reg;
  logic [1:0]           a_sel_reg;
  logic                 b_sel_reg;
  logic [4:0]           rs1_reg;
  logic [4:0]           rs2_reg;
  logic [4:0]           rd_reg;
  logic                 rd_we_reg;
  logic [31:0]          imm_reg;
  logic [31:0]          pc_reg;
  logic                 illegal_reg;
  logic [CNT_W-1:0]     instr_cnt_reg;
  logic [ILL_CNT_W-1:0] illegal_cnt_reg;

  // Decoded bundle for the instruction currently on the input
  logic       legal_next;
  logic [4:0] raw_alu_next;
  logic [1:0] raw_a_sel_next;
  logic       raw_b_sel_next;
  logic [31:0] raw_imm_next;
  logic [4:0] alu_ctr_next;
  logic [1:0] a_sel_next;
  logic       b_sel_next;
  logic [4:0] rs2_next;
  logic       rd_we_next;
  logic [31:0] imm_next;

  logic in_xfer;
  logic out_xfer;

  // The output register can take a new bundle when empty or being drained
  assign in_ready = !valid_reg || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_reg && out_ready;

  // Raw opcode/funct decode; legality decides later whether it is kept
  always_comb begin
    legal_next     = 1'b0;
    raw_alu_next   = ALU_ADD;
    raw_a_sel_next = ASEL_RS1;
    raw_b_sel_next = 1'b0;
    raw_imm_next   = 32'd0;
    rs2_next       = 5'd0;
    case (opcode)
      OPC_OP: begin
        // rs2 is an OP field regardless of whether funct7/funct3 is valid
        rs2_next = in_inst[24:20];
        if (funct7 == F7_BASE) begin
          legal_next = 1'b1;
          case (funct3)
            3'b000:  raw_alu_next = ALU_ADD;
            3'b001:  raw_alu_next = ALU_SLL;
            3'b010:  raw_alu_next = ALU_SLT;
            3'b011:  raw_alu_next = ALU_SLTU;
            3'b100:  raw_alu_next = ALU_XOR;
            3'b101:  raw_alu_next = ALU_SRL;
            3'b110:  raw_alu_next = ALU_OR;
            default: raw_alu_next = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            legal_next   = 1'b1;
            raw_alu_next = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            legal_next   = 1'b1;
            raw_alu_next = ALU_SRA;
          end
        end
      end
      OPC_OP_IMM: begin
        raw_b_sel_next = 1'b1;
        raw_imm_next   = {{20{in_inst[31]}}, in_inst[31:20]};
        case (funct3)
          3'b000: begin legal_next = 1'b1; raw_alu_next = ALU_ADDI;  end
          3'b010: begin legal_next = 1'b1; raw_alu_next = ALU_SLTI;  end
          3'b011: begin legal_next = 1'b1; raw_alu_next = ALU_SLTIU; end
          3'b100: begin legal_next = 1'b1; raw_alu_next = ALU_XORI;  end
          3'b110: begin legal_next = 1'b1; raw_alu_next = ALU_ORI;   end
          3'b111: begin legal_next = 1'b1; raw_alu_next = ALU_ANDI;  end
          3'b001: begin
            // Shift-immediates reuse the top of the I-immediate as funct7
            if (funct7 == F7_BASE) begin
              legal_next   = 1'b1;
              raw_alu_next = ALU_SLLI;
            end
          end
          default: begin
            if (funct7 == F7_BASE) begin
              legal_next   = 1'b1;
              raw_alu_next = ALU_SRLI;
            end else if (funct7 == F7_ALT) begin
              legal_next   = 1'b1;
              raw_alu_next = ALU_SRAI;
            end
          end
        endcase
      end
      OPC_LUI: begin
        legal_next     = 1'b1;
        raw_a_sel_next = ASEL_ZERO;
        raw_b_sel_next = 1'b1;
        raw_imm_next   = {in_inst[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        legal_next     = 1'b1;
        raw_a_sel_next = ASEL_PC;
        raw_b_sel_next = 1'b1;
        raw_imm_next   = {in_inst[31:12], 12'd0};
      end
      default: begin
        legal_next = 1'b0;
      end
    endcase
  end

  // Illegal encodings present a neutral bundle so execute cannot act on it
  always_comb begin
    alu_ctr_next = legal_next ? raw_alu_next   : ALU_ADD;
    a_sel_next   = legal_next ? raw_a_sel_next : ASEL_RS1;
    b_sel_next   = legal_next ? raw_b_sel_next : 1'b0;
    imm_next     = legal_next ? raw_imm_next   : 32'd0;
    rd_we_next   = legal_next && (in_inst[11:7] != 5'd0);
  end

  // Output register: flush empties it, accepted input loads it, drain clears valid
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg   <= 1'b0;
      alu_ctr_reg <= 5'd0;
      a_sel_reg   <= 2'd0;
      b_sel_reg   <= 1'b0;
      rs1_reg     <= 5'd0;
      rs2_reg     <= 5'd0;
      rd_reg      <= 5'd0;
      rd_we_reg   <= 1'b0;
      imm_reg     <= 32'd0;
      pc_reg      <= 32'd0;
      illegal_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (in_xfer) begin
      valid_reg   <= 1'b1;
      alu_ctr_reg <= alu_ctr_next;
      a_sel_reg   <= a_sel_next;
      b_sel_reg   <= b_sel_next;
      rs1_reg     <= in_inst[19:15];
      rs2_reg     <= rs2_next;
      rd_reg      <= in_inst[11:7];
      rd_we_reg   <= rd_we_next;
      imm_reg     <= imm_next;
      pc_reg      <= in_pc;
      illegal_reg <= !legal_next;
    end else if (out_xfer) begin
      valid_reg <= 1'b0;
    end
  end

  // Event counters advance on every bundle handed to execute, flush or not
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_reg   <= '0;
      illegal_cnt_reg <= '0;
    end else if (out_xfer) begin
      instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
      if (illegal_reg && (illegal_cnt_reg != {ILL_CNT_W{1'b1}})) begin
        illegal_cnt_reg <= illegal_cnt_reg + ILL_CNT_W'(1);
      end
    end
  end

  assign out_valid     = valid_reg;
  assign out_alu_ctr   = alu_ctr_reg;
  assign out_a_sel     = a_sel_reg;
  assign out_b_sel     = b_sel_reg;
  assign out_rs1       = rs1_reg;
  assign out_rs2       = rs2_reg;
  assign out_rd        = rd_reg;
  assign out_rd_we     = rd_we_reg;
  assign out_imm       = imm_reg;
  assign out_pc        = pc_reg;
  assign out_illegal   = illegal_reg;
  assign instr_count   = instr_cnt_reg;
  assign illegal_count = illegal_cnt_reg;

endmodule
